// File: rtl/hist_eq_axis_out_buffer.sv
// rtl/hist_eq_axis_out_buffer.sv - frame-dropping output FIFO for the histogram-equalised video stream
module hist_eq_axis_out_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 2048,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                      i_sys_clk,
   input  logic                      i_sys_aresetn,
   input  logic [3*DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                      s_axis_tvalid,
   input  logic                      s_axis_tuser,
   input  logic                      s_axis_tlast,
   output logic [3*DATA_WIDTH-1:0]   m_axis_tdata,
   output logic                      m_axis_tvalid,
   output logic                      m_axis_tuser,
   output logic                      m_axis_tlast,
   input  logic                      m_axis_tready,
   output logic [$clog2(DEPTH):0]    o_fill_level,
   output logic                      o_overflow,
   output logic [CNT_WIDTH-1:0]      o_drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = 3 * DATA_WIDTH;
   localparam int EW = PW + 2;
   localparam logic [AW:0]          FULL_LVL = (AW + 1)'(DEPTH);
   localparam logic [AW:0]          LVL_ONE  = 1;
   localparam logic [AW-1:0]        PTR_ONE  = 1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;

   typedef enum logic [1:0] {ST_SYNC, ST_PASS, ST_DROP} state_t;

   logic [EW-1:0]        mem_q [DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [AW:0]          fill_q, fill_d;
   state_t               state_q, state_d;
   logic                 ovf_q, ovf_d;
   logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
   logic                 out_valid_q, out_valid_d;
   logic [EW-1:0]        out_word_q, out_word_d;
   logic                 wr_en, rd_en, full;

   // Full is judged on the registered level only; a same-cycle read never makes room for a write.
   assign full  = (fill_q == FULL_LVL);
   assign rd_en = (fill_q != '0) && (!out_valid_q || m_axis_tready);

   // Write-side FSM: align to a frame start, then drop whole frames on overflow.
   always_comb begin
      state_d    = state_q;
      wr_en      = 1'b0;
      ovf_d      = 1'b0;
      drop_cnt_d = drop_cnt_q;
      case (state_q)
         ST_SYNC, ST_DROP: begin
            if (s_axis_tvalid && s_axis_tuser && !full) begin
               wr_en   = 1'b1;
               state_d = ST_PASS;
            end
         end
         ST_PASS: begin
            if (s_axis_tvalid) begin
               if (!full) begin
                  wr_en = 1'b1;
               end else begin
                  ovf_d   = 1'b1;
                  state_d = ST_DROP;
                  if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_ONE;
               end
            end
         end
         default: state_d = ST_SYNC;
      endcase
   end

   // Pointer and level bookkeeping plus the output register load/hold/empty decision.
   always_comb begin
      wr_ptr_d    = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d    = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      fill_d      = fill_q;
      out_valid_d = out_valid_q;
      out_word_d  = out_word_q;
      if (wr_en && !rd_en) fill_d = fill_q + LVL_ONE;
      else if (!wr_en && rd_en) fill_d = fill_q - LVL_ONE;
      if (rd_en) begin
         out_valid_d = 1'b1;
         out_word_d  = mem_q[rd_ptr_q];
      end else if (m_axis_tready) begin
         out_valid_d = 1'b0;
      end
   end

   // Storage array; contents need no reset because the level and pointers guard every read.
   always_ff @(posedge i_sys_clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
   end

   // State registers; reset discards buffered data and returns to frame alignment.
   always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
      if (!i_sys_aresetn) begin
         state_q     <= ST_SYNC;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fill_q      <= '0;
         ovf_q       <= 1'b0;
         drop_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_word_q  <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fill_q      <= fill_d;
         ovf_q       <= ovf_d;
         drop_cnt_q  <= drop_cnt_d;
         out_valid_q <= out_valid_d;
         out_word_q  <= out_word_d;
      end
   end

   assign m_axis_tvalid = out_valid_q;
   assign m_axis_tuser  = out_word_q[EW-1];
   assign m_axis_tlast  = out_word_q[EW-2];
   assign m_axis_tdata  = out_word_q[PW-1:0];
   assign o_fill_level  = fill_q;
   assign o_overflow    = ovf_q;
   assign o_drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_hist_eq_axis_out_buffer.sv
// tb/tb_hist_eq_axis_out_buffer.sv - scoreboard bench for the frame-dropping output buffer
module tb_hist_eq_axis_out_buffer;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int CW    = 16;

   logic          clk, rst_n;
   logic [3*DW-1:0] s_tdata, m_tdata;
   logic          s_tvalid, s_tuser, s_tlast;
   logic          m_tvalid, m_tuser, m_tlast, m_tready;
   logic [$clog2(DEPTH):0] fill;
   logic          ovf;
   logic [CW-1:0] drop_cnt;

   hist_eq_axis_out_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
      .i_sys_clk(clk), .i_sys_aresetn(rst_n),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
      .m_axis_tready(m_tready), .o_fill_level(fill), .o_overflow(ovf), .o_drop_count(drop_cnt)
   );

   typedef struct {
      int n_junk; int w; int h; int n_frames; int gap; int rmode; bit chk_fill;
      int exp_out; int exp_drop;
   } vec_t;

   vec_t          vecs[4];
   logic [25:0]   exp_q[$];
   int            n_checks = 0, n_fail = 0, out_cnt = 0, cyc = 0, rmode = 0;
   int            pix = 0;
   bit            chk_fill_en = 0, stall = 0;
   logic [25:0]   hold;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      check(name, act === exp, act, exp);
   endtask

   // Output monitor: scoreboard pop on transfer, stall stability, optional fill bound.
   always @(negedge clk) begin
      logic [25:0] got, e;
      got = {m_tuser, m_tlast, m_tdata};
      if (!rst_n) begin
         stall = 0;
      end else begin
         if (stall) begin
            check("stall_valid", m_tvalid === 1'b1, 32'(m_tvalid), 1);
            check("stall_hold", got === hold, 32'(got), 32'(hold));
         end
         if (chk_fill_en) check("fill_le1", fill <= 1, 32'(fill), 1);
         if (m_tvalid && m_tready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
               check("extra_beat", 1'b0, 32'(got), 0);
            end else begin
               e = exp_q.pop_front();
               check_eq("beat", 32'(got), 32'(e));
            end
         end
         stall = m_tvalid && !m_tready;
         hold  = got;
      end
   end

   task automatic set_mode(input int m);
      rmode = m;
      m_tready = (m == 0) ? 1'b1 : (m == 1) ? cyc[0] : 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      set_mode(rmode);
   endtask

   task automatic send(input logic [23:0] d, input logic u, input logic l, input bit keep);
      s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
      if (keep) exp_q.push_back({u, l, d});
      tick();
      s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic send_frame(input int w, input int h, input int gap);
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++) begin
            send(24'(pix), (x == 0 && y == 0), (x == w - 1), 1'b1);
            pix++;
            for (int g = 1; g < gap; g++) tick();
         end
   endtask

   task automatic drain(input int max);
      int i;
      set_mode(0);
      i = 0;
      while (i < max && (exp_q.size() != 0 || m_tvalid)) begin
         tick();
         i++;
      end
      check("drain_done", exp_q.size() == 0 && !m_tvalid, 32'(exp_q.size()), 0);
      repeat (4) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      tick(); tick();
      rst_n = 1'b1;
      out_cnt = 0;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
      vecs[0] = '{n_junk:10, w:32, h:4,  n_frames:1, gap:1, rmode:0, chk_fill:1, exp_out:128,  exp_drop:0};
      vecs[1] = '{n_junk:0,  w:64, h:16, n_frames:2, gap:1, rmode:0, chk_fill:1, exp_out:2048, exp_drop:0};
      vecs[2] = '{n_junk:3,  w:32, h:8,  n_frames:1, gap:4, rmode:1, chk_fill:0, exp_out:256,  exp_drop:0};
      vecs[3] = '{n_junk:5,  w:16, h:4,  n_frames:1, gap:2, rmode:0, chk_fill:1, exp_out:64,   exp_drop:0};

      // Reset values
      tick();
      check_eq("rst_tvalid", 32'(m_tvalid), 0);
      check_eq("rst_tdata", 32'(m_tdata), 0);
      check_eq("rst_tuser_tlast", 32'({m_tuser, m_tlast}), 0);
      check_eq("rst_fill", 32'(fill), 0);
      check_eq("rst_ovf", 32'(ovf), 0);
      check_eq("rst_drop", 32'(drop_cnt), 0);

      // Table-driven scenarios
      for (int v = 0; v < 4; v++) begin
         do_reset();
         set_mode(vecs[v].rmode);
         chk_fill_en = vecs[v].chk_fill;
         for (int j = 0; j < vecs[v].n_junk; j++) send(24'hABC000 + 24'(j), 1'b0, (j == 3), 1'b0);
         for (int f = 0; f < vecs[v].n_frames; f++) send_frame(vecs[v].w, vecs[v].h, vecs[v].gap);
         drain(6000);
         chk_fill_en = 0;
         check_eq("vec_out_count", 32'(out_cnt), 32'(vecs[v].exp_out));
         check_eq("vec_drop_count", 32'(drop_cnt), 32'(vecs[v].exp_drop));
      end

      // Two-cycle latency from input sample to m_axis_tvalid
      do_reset();
      set_mode(0);
      send(24'h123456, 1'b1, 1'b0, 1'b1);
      check_eq("lat_edge_n", 32'(m_tvalid), 0);
      tick();
      check_eq("lat_edge_n1", 32'(m_tvalid), 1);
      check_eq("lat_tuser", 32'(m_tuser), 1);
      drain(100);

      // Overflow with consumer stalled: 17 kept, 18th drops the frame
      do_reset();
      set_mode(2);
      for (int i = 1; i <= 20; i++) begin
         send(24'h500000 + 24'(i), (i == 1), 1'b0, (i <= 17));
         check_eq("ovf_pulse", 32'(ovf), 32'(i == 18));
         if (i == 17) check_eq("ovf_fill17", 32'(fill), 16);
         if (i == 18) check_eq("ovf_count", 32'(drop_cnt), 1);
      end
      // Frame start while still full is discarded silently
      send(24'h5AAAAA, 1'b1, 1'b0, 1'b0);
      check_eq("resync_full_pulse", 32'(ovf), 0);
      check_eq("resync_full_count", 32'(drop_cnt), 1);
      check_eq("resync_full_fill", 32'(fill), 16);
      drain(200);
      check_eq("ovf_drained", 32'(out_cnt), 17);
      set_mode(0);
      send_frame(16, 2, 1);
      drain(200);
      check_eq("resync_count", 32'(drop_cnt), 1);
      check_eq("resync_out", 32'(out_cnt), 17 + 32);

      // Reset mid-stream with data buffered
      do_reset();
      set_mode(2);
      for (int i = 0; i < 11; i++) send(24'h700000 + 24'(i), (i == 0), 1'b0, 1'b0);
      check_eq("mid_fill", 32'(fill), 10);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_tvalid", 32'(m_tvalid), 0);
      check_eq("mid_rst_word", 32'({m_tuser, m_tlast, m_tdata}), 0);
      check_eq("mid_rst_fill", 32'(fill), 0);
      check_eq("mid_rst_flags", 32'({ovf, drop_cnt}), 0);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      out_cnt = 0;
      set_mode(0);
      for (int j = 0; j < 4; j++) send(24'h7F0000 + 24'(j), 1'b0, 1'b0, 1'b0);
      send_frame(8, 2, 1);
      drain(200);
      check_eq("mid_after_out", 32'(out_cnt), 16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hist_eq_axis_out_buffer.md
# hist_eq_axis_out_buffer

Output buffer that sits directly downstream of `hist_eq_module`. It absorbs the equalized 3-channel AXI4-Stream video, which has no backpressure, and presents it to a consumer that does honour `m_axis_tready`. The upstream stage cannot stall, so on overflow the buffer discards whole frames instead of corrupting line or frame geometry. It also aligns start-up to the first frame boundary and reports fill level and dropped-frame count.

## Interface
- `DATA_WIDTH`, 8: bits per channel; beat width is 3*DATA_WIDTH.
- `DEPTH`, 2048: FIFO memory entries; must be a power of two and at least 4.
- `CNT_WIDTH`, 16: width of the dropped-frame counter.

- `i_sys_clk`  in  1: single clock for the whole block.
- `i_sys_aresetn`  in  1: asynchronous, active-low reset.
- `s_axis_tdata`  in  3*DATA_WIDTH: input pixel (R,G,B).
- `s_axis_tvalid`  in  1: input beat valid; no ready is returned upstream.
- `s_axis_tuser`  in  1: start of frame (first pixel).
- `s_axis_tlast`  in  1: end of line.
- `m_axis_tdata`  out  3*DATA_WIDTH: output pixel.
- `m_axis_tvalid`  out  1: output beat valid.
- `m_axis_tuser`  out  1: start of frame.
- `m_axis_tlast`  out  1: end of line.
- `m_axis_tready`  in  1: consumer ready.
- `o_fill_level`  out  $clog2(DEPTH)+1: entries held in memory, excluding the output register.
- `o_overflow`  out  1: one-cycle pulse when a frame starts being dropped.
- `o_drop_count`  out  CNT_WIDTH: frames dropped since reset; saturates at all-ones.

## Operation
- Each memory entry stores {tuser, tlast, tdata}, width 3*DATA_WIDTH+2.
- Write-side FSM has three states: SYNC, PASS, DROP. The reset state is SYNC.
- **SYNC:** discard every beat until a beat with tuser=1 arrives.
  - If that beat arrives and the memory is not full, write it and go to PASS.
  - No counter or pulse is generated in SYNC.
- **PASS:** write every valid beat while fill_level < DEPTH.
  - If a valid beat arrives with fill_level == DEPTH, discard it, pulse `o_overflow`, increment `o_drop_count` (saturating), and go to DROP.
- **DROP:** discard all beats until a tuser=1 beat arrives while the memory is not full.
  - That beat is written and the FSM goes to PASS.
  - A tuser=1 beat that arrives while the memory is still full is discarded. The FSM stays in DROP with no additional pulse and no additional count.
- The full test uses the registered fill level at the start of the cycle. A read in the same cycle does not free space for a simultaneous write.
- The partially delivered frame is not padded. The consumer sees a truncated frame followed by the next tuser.
- **Read side:** the memory feeds a single output register, giving first-word-fall-through behaviour.
  - The output register loads from memory when the memory is non-empty and either `m_axis_tvalid` is 0 or `m_axis_tready` is 1.
  - Otherwise the register holds its contents.
- `o_fill_level` changes by +1 per write, -1 per read, and stays unchanged when both occur in the same cycle.
- Read and write pointers are $clog2(DEPTH) bits wide and wrap naturally.

## Timing
- **Reset values:**
  - `m_axis_tvalid`, `m_axis_tuser`, `m_axis_tlast`, `o_overflow` = 0.
  - `m_axis_tdata` = 0.
  - `o_fill_level` = 0.
  - `o_drop_count` = 0.
  - Pointers = 0.
  - FSM = SYNC.
- Reset asserted mid-stream clears all of the above immediately. Buffered data is lost.
- **Latency:** a beat sampled at clock edge N is written to memory at edge N. It is loaded into the output register at edge N+1 if the register is free. `m_axis_tvalid` is therefore high 2 cycles after the input beat is sampled.
- **Handshake:** a transfer occurs on an edge where `m_axis_tvalid` && `m_axis_tready`. While `m_axis_tvalid`=1 and `m_axis_tready`=0, the outputs `tdata`, `tuser` and `tlast` stay stable.
- `m_axis_tvalid` never drops without a completed transfer.
- **Sustained throughput:** 1 beat/cycle with `m_axis_tready` held at 1. `o_fill_level` stays ≤ 1 in that case.
- **Capacity:** DEPTH+1 beats can be accepted without any read (DEPTH in memory plus 1 in the output register).
- `o_overflow` is asserted in the cycle after the dropping edge, for exactly one cycle.

## Test plan
- **Mid-frame start:** reset, then stream 10 beats with tuser=0, then a 1280x4 frame (tuser on first pixel, tlast every 1280 beats), with `m_axis_tready`=1.
  - The 10 beats never appear.
  - The first output beat has tuser=1.
  - Exactly 5120 beats come out.
  - `o_drop_count`=0.
- **Pass-through:** two 1280x1024 frames with an incrementing pixel pattern and `m_axis_tready`=1.
  - Output equals input in order.
  - `m_axis_tvalid` rises 2 cycles after the first input beat.
  - `o_fill_level` ≤ 1 throughout.
- **Overflow (DEPTH=16):** hold `m_axis_tready`=0 and send 20 beats of one frame.
  - Beats 1–17 are retained.
  - Beat 18 produces one `o_overflow` pulse and `o_drop_count`=1.
  - After releasing ready, exactly 17 beats come out, in order.
- **Resync while still full (DEPTH=16):** in DROP with the memory still full, a tuser beat arrives.
  - The beat is discarded and no pulse occurs.
  - Drain the buffer, send the next tuser: the beat is written, `o_drop_count` stays 1, and the next frame is complete.
- **Backpressure:** a full frame with `m_axis_tready` toggled 1-cycle-on/1-cycle-off and input valid every 4th cycle.
  - No drops.
  - `m_axis_tdata`, `tuser` and `tlast` are stable during every stall.
- **Reset mid-stream:** assert `i_sys_aresetn`=0 with `o_fill_level`=100.
  - All outputs read 0 immediately.
  - After release, output begins only at the next tuser.
